// File: rtl/cache_req_buffer_pkg.sv
// Shared field layout for packed cache request entries.
// The struct order must track the LSB/MSB constants below.
package cache_req_buffer_pkg;

    localparam int unsigned REQ_ADDR_W  = 32;
    localparam int unsigned REQ_DATA_W  = 32;
    localparam int unsigned DATA_BYTES  = REQ_DATA_W / 8;
    localparam int unsigned WORD_LSB    = $clog2(DATA_BYTES);
    localparam int unsigned WORD_ADDR_W = REQ_ADDR_W - WORD_LSB;

    localparam int unsigned LOAD_LSB    = 0;
    localparam int unsigned MODE_LSB    = 1;
    localparam int unsigned STRB_LSB    = 2;
    localparam int unsigned STRB_MSB    = STRB_LSB + DATA_BYTES - 1;
    localparam int unsigned DATA_LSB    = STRB_MSB + 1;
    localparam int unsigned DATA_MSB    = DATA_LSB + REQ_DATA_W - 1;
    localparam int unsigned ADDR_LSB    = DATA_MSB + 1;
    localparam int unsigned ADDR_MSB    = ADDR_LSB + REQ_ADDR_W - 1;
    localparam int unsigned REQ_ENTRY_W = ADDR_MSB + 1;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
        logic [DATA_BYTES-1:0] strb;
        logic                  mode;
        logic                  load;
    } cache_req_t;

    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [REQ_ADDR_W-1:0] addr);
        return addr[REQ_ADDR_W-1:WORD_LSB];
    endfunction

endpackage

// File: rtl/cache_req_fifo_mem.sv
// Entry storage with wrap-bit pointers and per-slot store-valid flags.
// Exposes every slot's word address so the top can do the hazard compare.
module cache_req_fifo_mem
    import cache_req_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        push_i,
    input  logic                                        pop_i,
    input  logic [REQ_ENTRY_W-1:0]                      wr_entry_i,
    output logic [REQ_ENTRY_W-1:0]                      rd_entry_o,
    output logic [(2**DEPTH_BITS)-1:0]                  store_vld_o,
    output logic [(2**DEPTH_BITS)-1:0][WORD_ADDR_W-1:0] slot_word_o,
    output logic [DEPTH_BITS:0]                         count_o,
    output logic                                        full_o,
    output logic                                        empty_o
);

    localparam int unsigned DEPTH = 2**DEPTH_BITS;

    cache_req_t            mem [DEPTH];
    cache_req_t            wr_entry;
    logic [DEPTH_BITS:0]   wr_ptr;
    logic [DEPTH_BITS:0]   rd_ptr;
    logic [DEPTH_BITS-1:0] wr_idx;
    logic [DEPTH_BITS-1:0] rd_idx;
    logic                  do_push;
    logic                  do_pop;

    assign wr_entry = cache_req_t'(wr_entry_i);
    assign wr_idx   = wr_ptr[DEPTH_BITS-1:0];
    assign rd_idx   = rd_ptr[DEPTH_BITS-1:0];

    assign empty_o  = (wr_ptr == rd_ptr);
    assign full_o   = (wr_idx == rd_idx) && (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]);
    assign count_o  = wr_ptr - rd_ptr;

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;

    // Push and pop never target the same slot: that needs full or empty, both gated above.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            store_vld_o <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                store_vld_o[rd_idx] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr              <= wr_ptr + 1'b1;
                store_vld_o[wr_idx] <= ~wr_entry.load;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry_o = mem[rd_idx];

    always_comb begin
        slot_word_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_word_o[i] = word_addr(mem[i].addr);
        end
    end

endmodule

// File: rtl/cache_req_buffer.sv
// In-order CPU request buffer feeding the cache controller.
// Loads hitting a buffered store's word are held off until that store drains.
module cache_req_buffer
    import cache_req_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 2,
    parameter int unsigned ADDR_W     = REQ_ADDR_W,
    parameter int unsigned DATA_W     = REQ_DATA_W,
    parameter int unsigned ENTRY_W    = DATA_W + ADDR_W + 1 + DATA_W/8 + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_load_i,
    input  logic                  req_mode_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_data_i,
    input  logic [DATA_W/8-1:0]   req_strb_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ENTRY_W-1:0]    out_entry_o,
    output logic [DEPTH_BITS:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  hazard_o
);

    localparam int unsigned DEPTH = 2**DEPTH_BITS;

    logic [REQ_ENTRY_W-1:0]               push_entry;
    logic [REQ_ENTRY_W-1:0]               head_entry;
    logic [DEPTH-1:0]                     store_vld;
    logic [DEPTH-1:0][WORD_ADDR_W-1:0]    slot_word;
    logic                                 store_hit;
    logic                                 push;
    logic                                 pop;

    // Loads carry no payload, so their strobe/data fields are zeroed.
    always_comb begin
        push_entry                    = '0;
        push_entry[LOAD_LSB]          = req_load_i;
        push_entry[MODE_LSB]          = req_mode_i;
        push_entry[ADDR_MSB:ADDR_LSB] = req_addr_i;
        if (!req_load_i) begin
            push_entry[STRB_MSB:STRB_LSB] = req_strb_i;
            push_entry[DATA_MSB:DATA_LSB] = req_data_i;
        end
    end

    // Includes a head that pops this very cycle; the load simply goes one cycle later.
    always_comb begin
        store_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (store_vld[i] && (slot_word[i] == word_addr(req_addr_i))) begin
                store_hit = 1'b1;
            end
        end
    end

    assign hazard_o    = req_valid_i & req_load_i & store_hit;
    assign req_ready_o = ~full_o & ~hazard_o;
    assign out_valid_o = ~empty_o;
    assign push        = req_valid_i & req_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign out_entry_o = head_entry;

    cache_req_fifo_mem #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo_mem (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .pop_i       (pop),
        .wr_entry_i  (push_entry),
        .rd_entry_o  (head_entry),
        .store_vld_o (store_vld),
        .slot_word_o (slot_word),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

endmodule

// File: tb/tb_cache_req_buffer.sv
// Bench for cache_req_buffer: directed table, hand sequences and random traffic
// checked against a queue-based model of the buffer.
module tb_cache_req_buffer;

    logic        clk;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        out_valid;
    logic        out_ready;
    logic [69:0] out_entry;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        hazard;

    cache_req_buffer #(
        .DEPTH_BITS (2),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_load_i  (req_load),
        .req_mode_i  (req_mode),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_strb_i  (req_strb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_entry_o (out_entry),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .hazard_o    (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        mode;
        logic        load;
    } req_t;

    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        o;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_hz;
        logic        e_vld;
    } vec_t;

    req_t exp_q[$];
    req_t pend;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entry layout from MSB: addr(32) data(32) strb(4) mode load.
    function automatic logic [69:0] pack_exp(input req_t r);
        return {r.addr, r.data, r.strb, r.mode, r.load};
    endfunction

    task automatic apply(input logic v, input logic l, input logic m, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic o,
                         output bit push, output bit pop);
        int unsigned sz;
        bit          hz;
        req_valid = v;
        req_load  = l;
        req_mode  = m;
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
        out_ready = o;
        @(negedge clk);
        sz = exp_q.size();
        hz = 1'b0;
        foreach (exp_q[k])
            if (!exp_q[k].load && ((exp_q[k].addr >> 2) == (a >> 2))) hz = 1'b1;
        hz = hz && v && l;
        chk("count", 70'(count), 70'(sz));
        chk("empty", 70'(empty), 70'(sz == 0));
        chk("full", 70'(full), 70'(sz == 4));
        chk("out_valid", 70'(out_valid), 70'(sz != 0));
        chk("hazard", 70'(hazard), 70'(hz));
        chk("req_ready", 70'(req_ready), 70'(sz < 4 && !hz));
        if (sz != 0) chk("out_entry", out_entry, pack_exp(exp_q[0]));
        push = v && (sz < 4) && !hz;
        pop  = o && (sz != 0);
        pend.addr = a;
        pend.mode = m;
        pend.load = l;
        pend.data = l ? 32'h0 : d;
        pend.strb = l ? 4'h0 : s;
    endtask

    task automatic commit(input bit push, input bit pop);
        @(posedge clk);
        if (pop) exp_q.delete(0);
        if (push) exp_q.push_back(pend);
        #1;
    endtask

    task automatic step(input logic v, input logic l, input logic m, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic o);
        bit pu, po;
        apply(v, l, m, a, d, s, o, pu, po);
        commit(pu, po);
    endtask

    function automatic vec_t mk(input logic v, input logic l, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s, input logic o,
                                input logic [2:0] c, input logic r, input logic h, input logic vl);
        vec_t t;
        t.v = v; t.l = l; t.a = a; t.d = d; t.s = s; t.o = o;
        t.e_cnt = c; t.e_rdy = r; t.e_hz = h; t.e_vld = vl;
        return t;
    endfunction

    vec_t tbl [11];

    initial begin
        bit          pu, po;
        logic [31:0] head_addr;

        tbl[0]  = mk(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 1, 0, 1);
        tbl[2]  = mk(1, 1, 32'h102, 32'h0,        4'h0, 0, 1, 0, 1, 1);
        tbl[3]  = mk(1, 1, 32'h102, 32'h0,        4'h0, 1, 1, 0, 1, 1);
        tbl[4]  = mk(1, 1, 32'h102, 32'h0,        4'h0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 32'h200, 32'h12345678, 4'h3, 0, 1, 1, 0, 1);
        tbl[6]  = mk(1, 1, 32'h204, 32'h0,        4'h0, 0, 2, 1, 0, 1);
        tbl[7]  = mk(0, 0, 32'h0,   32'h0,        4'h0, 1, 3, 1, 0, 1);
        tbl[8]  = mk(0, 0, 32'h0,   32'h0,        4'h0, 1, 2, 1, 0, 1);
        tbl[9]  = mk(0, 0, 32'h0,   32'h0,        4'h0, 1, 1, 1, 0, 1);
        tbl[10] = mk(0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 0);

        rst_ni = 1'b0;
        req_valid = 1'b0; req_load = 1'b0; req_mode = 1'b0;
        req_addr = '0; req_data = '0; req_strb = '0; out_ready = 1'b0;
        #12;
        chk("rst_count", 70'(count), 70'(0));
        chk("rst_empty", 70'(empty), 70'(1));
        chk("rst_full", 70'(full), 70'(0));
        chk("rst_out_valid", 70'(out_valid), 70'(0));
        chk("rst_hazard", 70'(hazard), 70'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].v, tbl[i].l, 1'b0, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].o, pu, po);
            chk($sformatf("tbl%0d_count", i), 70'(count), 70'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ready", i), 70'(req_ready), 70'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_hazard", i), 70'(hazard), 70'(tbl[i].e_hz));
            chk($sformatf("tbl%0d_valid", i), 70'(out_valid), 70'(tbl[i].e_vld));
            if (i == 1) chk("tbl1_entry", out_entry, {32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0});
            commit(pu, po);
        end

        // Fill with four loads, then drain and check order.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'(i * 4), 32'hFFFF_FFFF, 4'hF, 0);
        apply(1, 1, 0, 32'h40, 32'h0, 4'h0, 0, pu, po);
        chk("fill_full", 70'(full), 70'(1));
        chk("fill_ready", 70'(req_ready), 70'(0));
        chk("fill_count", 70'(count), 70'(4));
        commit(pu, po);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, pu, po);
            head_addr = out_entry[69:38];
            chk("drain_addr", 70'(head_addr), 70'(i * 4));
            commit(pu, po);
        end
        apply(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, pu, po);
        chk("drain_empty", 70'(empty), 70'(1));
        commit(pu, po);

        // Steady push+pop at occupancy two; pointers wrap several times.
        step(1, 0, 0, 32'h300, 32'hA000_0000, 4'h1, 0);
        step(1, 0, 1, 32'h304, 32'hA000_0001, 4'h2, 0);
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 1'(i), 32'h310 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'(i), 1, pu, po);
            chk("stream_count", 70'(count), 70'(2));
            commit(pu, po);
        end
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1);

        // Asynchronous reset with three entries buffered.
        step(1, 0, 0, 32'h500, 32'h1111_1111, 4'hF, 0);
        step(1, 1, 0, 32'h600, 32'h0, 4'h0, 0);
        step(1, 0, 0, 32'h700, 32'h2222_2222, 4'h0, 0);
        req_valid = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_count", 70'(count), 70'(0));
        chk("arst_out_valid", 70'(out_valid), 70'(0));
        chk("arst_empty", 70'(empty), 70'(1));
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1);

        // Random traffic concentrated on four words so hazards occur often.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
